// File: rtl/first_layer_conv3x3s2.sv
// First CNN layer: 3x3 stride-2 convolution of a raster-ordered RGB stream into
// 32 output channels with fixed weights w[k][c] = k*(c+1) on every tap.
module first_layer_conv3x3s2 #(
    parameter int D          = 9,
    parameter int data_width = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  valid_in_1,
    input  logic                  valid_in_2,
    input  logic                  valid_in_3,
    input  logic [data_width-1:0] pxl_in_1,
    input  logic [data_width-1:0] pxl_in_2,
    input  logic [data_width-1:0] pxl_in_3,
    output logic [data_width-1:0] pxl_out_1,  output logic [data_width-1:0] pxl_out_2,
    output logic [data_width-1:0] pxl_out_3,  output logic [data_width-1:0] pxl_out_4,
    output logic [data_width-1:0] pxl_out_5,  output logic [data_width-1:0] pxl_out_6,
    output logic [data_width-1:0] pxl_out_7,  output logic [data_width-1:0] pxl_out_8,
    output logic [data_width-1:0] pxl_out_9,  output logic [data_width-1:0] pxl_out_10,
    output logic [data_width-1:0] pxl_out_11, output logic [data_width-1:0] pxl_out_12,
    output logic [data_width-1:0] pxl_out_13, output logic [data_width-1:0] pxl_out_14,
    output logic [data_width-1:0] pxl_out_15, output logic [data_width-1:0] pxl_out_16,
    output logic [data_width-1:0] pxl_out_17, output logic [data_width-1:0] pxl_out_18,
    output logic [data_width-1:0] pxl_out_19, output logic [data_width-1:0] pxl_out_20,
    output logic [data_width-1:0] pxl_out_21, output logic [data_width-1:0] pxl_out_22,
    output logic [data_width-1:0] pxl_out_23, output logic [data_width-1:0] pxl_out_24,
    output logic [data_width-1:0] pxl_out_25, output logic [data_width-1:0] pxl_out_26,
    output logic [data_width-1:0] pxl_out_27, output logic [data_width-1:0] pxl_out_28,
    output logic [data_width-1:0] pxl_out_29, output logic [data_width-1:0] pxl_out_30,
    output logic [data_width-1:0] pxl_out_31, output logic [data_width-1:0] pxl_out_32,
    output logic valid_out_1,  output logic valid_out_2,  output logic valid_out_3,
    output logic valid_out_4,  output logic valid_out_5,  output logic valid_out_6,
    output logic valid_out_7,  output logic valid_out_8,  output logic valid_out_9,
    output logic valid_out_10, output logic valid_out_11, output logic valid_out_12,
    output logic valid_out_13, output logic valid_out_14, output logic valid_out_15,
    output logic valid_out_16, output logic valid_out_17, output logic valid_out_18,
    output logic valid_out_19, output logic valid_out_20, output logic valid_out_21,
    output logic valid_out_22, output logic valid_out_23, output logic valid_out_24,
    output logic valid_out_25, output logic valid_out_26, output logic valid_out_27,
    output logic valid_out_28, output logic valid_out_29, output logic valid_out_30,
    output logic valid_out_31, output logic valid_out_32
);

    localparam int SR_LEN = 2 * D + 3;
    localparam int CW     = (D > 1) ? $clog2(D) : 1;
    localparam logic [CW-1:0] LAST = CW'(D - 1);

    logic [data_width-1:0] sr_r [3][SR_LEN];
    logic [data_width-1:0] out_r [32];
    logic [CW-1:0]         col_r;
    logic [CW-1:0]         row_r;
    logic                  valid_r;

    logic                  accept_s;
    logic                  win_done_s;
    logic [data_width-1:0] px_s   [3];
    logic [data_width-1:0] csum_s [3];
    logic [data_width-1:0] total_s;

    // Accept qualification, stride-2 window detection and the shared weighted sum.
    // Every weight of channel k is k*(c+1), so out_k = k * (S_R + 2*S_G + 3*S_B).
    always_comb begin
        px_s[0]    = pxl_in_1;
        px_s[1]    = pxl_in_2;
        px_s[2]    = pxl_in_3;
        accept_s   = valid_in_1 & valid_in_2 & valid_in_3;
        win_done_s = (row_r >= CW'(2)) && (col_r >= CW'(2)) && !row_r[0] && !col_r[0];
        for (int c = 0; c < 3; c++) begin
            // sr_r[c][j] holds the pixel j+1 accepts ago
            csum_s[c] = px_s[c] + sr_r[c][0] + sr_r[c][1]
                      + sr_r[c][D-1] + sr_r[c][D] + sr_r[c][D+1]
                      + sr_r[c][2*D-1] + sr_r[c][2*D] + sr_r[c][2*D+1];
        end
        total_s = csum_s[0] + (csum_s[1] << 1) + (csum_s[2] << 1) + csum_s[2];
    end

    // Window storage, raster position and registered results.
    always_ff @(posedge clk) begin
        if (!reset) begin
            col_r   <= '0;
            row_r   <= '0;
            valid_r <= 1'b0;
            for (int c = 0; c < 3; c++) begin
                for (int j = 0; j < SR_LEN; j++) begin
                    sr_r[c][j] <= '0;
                end
            end
            for (int k = 0; k < 32; k++) begin
                out_r[k] <= '0;
            end
        end else begin
            valid_r <= accept_s && win_done_s;
            if (accept_s) begin
                for (int c = 0; c < 3; c++) begin
                    sr_r[c][0] <= px_s[c];
                    for (int j = 1; j < SR_LEN; j++) begin
                        sr_r[c][j] <= sr_r[c][j-1];
                    end
                end
                if (col_r == LAST) begin
                    col_r <= '0;
                    row_r <= (row_r == LAST) ? '0 : row_r + CW'(1);
                end else begin
                    col_r <= col_r + CW'(1);
                end
                if (win_done_s) begin
                    for (int k = 0; k < 32; k++) begin
                        out_r[k] <= total_s * data_width'(k + 1);
                    end
                end
            end
        end
    end

    assign pxl_out_1  = out_r[0];  assign valid_out_1  = valid_r;
    assign pxl_out_2  = out_r[1];  assign valid_out_2  = valid_r;
    assign pxl_out_3  = out_r[2];  assign valid_out_3  = valid_r;
    assign pxl_out_4  = out_r[3];  assign valid_out_4  = valid_r;
    assign pxl_out_5  = out_r[4];  assign valid_out_5  = valid_r;
    assign pxl_out_6  = out_r[5];  assign valid_out_6  = valid_r;
    assign pxl_out_7  = out_r[6];  assign valid_out_7  = valid_r;
    assign pxl_out_8  = out_r[7];  assign valid_out_8  = valid_r;
    assign pxl_out_9  = out_r[8];  assign valid_out_9  = valid_r;
    assign pxl_out_10 = out_r[9];  assign valid_out_10 = valid_r;
    assign pxl_out_11 = out_r[10]; assign valid_out_11 = valid_r;
    assign pxl_out_12 = out_r[11]; assign valid_out_12 = valid_r;
    assign pxl_out_13 = out_r[12]; assign valid_out_13 = valid_r;
    assign pxl_out_14 = out_r[13]; assign valid_out_14 = valid_r;
    assign pxl_out_15 = out_r[14]; assign valid_out_15 = valid_r;
    assign pxl_out_16 = out_r[15]; assign valid_out_16 = valid_r;
    assign pxl_out_17 = out_r[16]; assign valid_out_17 = valid_r;
    assign pxl_out_18 = out_r[17]; assign valid_out_18 = valid_r;
    assign pxl_out_19 = out_r[18]; assign valid_out_19 = valid_r;
    assign pxl_out_20 = out_r[19]; assign valid_out_20 = valid_r;
    assign pxl_out_21 = out_r[20]; assign valid_out_21 = valid_r;
    assign pxl_out_22 = out_r[21]; assign valid_out_22 = valid_r;
    assign pxl_out_23 = out_r[22]; assign valid_out_23 = valid_r;
    assign pxl_out_24 = out_r[23]; assign valid_out_24 = valid_r;
    assign pxl_out_25 = out_r[24]; assign valid_out_25 = valid_r;
    assign pxl_out_26 = out_r[25]; assign valid_out_26 = valid_r;
    assign pxl_out_27 = out_r[26]; assign valid_out_27 = valid_r;
    assign pxl_out_28 = out_r[27]; assign valid_out_28 = valid_r;
    assign pxl_out_29 = out_r[28]; assign valid_out_29 = valid_r;
    assign pxl_out_30 = out_r[29]; assign valid_out_30 = valid_r;
    assign pxl_out_31 = out_r[30]; assign valid_out_31 = valid_r;
    assign pxl_out_32 = out_r[31]; assign valid_out_32 = valid_r;

endmodule

// File: tb/tb_first_layer_conv3x3s2.sv
// Directed bench for first_layer_conv3x3s2: reset, constant/ramp/negative frames,
// stalls, back-to-back frames and mid-frame reset, with hand-computed anchor values.
module tb_first_layer_conv3x3s2;

    localparam int D = 9;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         v1, v2, v3;
    logic [W-1:0] p1, p2, p3;
    logic [W-1:0] po [1:32];
    logic [32:1]  vo;

    int errors = 0;
    int checks = 0;
    int mode;
    int idx;
    int pulses;
    logic [W-1:0] last_exp [1:32];

    always #5 clk = ~clk;

    first_layer_conv3x3s2 #(.D(D), .data_width(W)) dut (
        .clk(clk), .reset(reset),
        .valid_in_1(v1), .valid_in_2(v2), .valid_in_3(v3),
        .pxl_in_1(p1), .pxl_in_2(p2), .pxl_in_3(p3),
        .pxl_out_1(po[1]),   .pxl_out_2(po[2]),   .pxl_out_3(po[3]),   .pxl_out_4(po[4]),
        .pxl_out_5(po[5]),   .pxl_out_6(po[6]),   .pxl_out_7(po[7]),   .pxl_out_8(po[8]),
        .pxl_out_9(po[9]),   .pxl_out_10(po[10]), .pxl_out_11(po[11]), .pxl_out_12(po[12]),
        .pxl_out_13(po[13]), .pxl_out_14(po[14]), .pxl_out_15(po[15]), .pxl_out_16(po[16]),
        .pxl_out_17(po[17]), .pxl_out_18(po[18]), .pxl_out_19(po[19]), .pxl_out_20(po[20]),
        .pxl_out_21(po[21]), .pxl_out_22(po[22]), .pxl_out_23(po[23]), .pxl_out_24(po[24]),
        .pxl_out_25(po[25]), .pxl_out_26(po[26]), .pxl_out_27(po[27]), .pxl_out_28(po[28]),
        .pxl_out_29(po[29]), .pxl_out_30(po[30]), .pxl_out_31(po[31]), .pxl_out_32(po[32]),
        .valid_out_1(vo[1]),   .valid_out_2(vo[2]),   .valid_out_3(vo[3]),   .valid_out_4(vo[4]),
        .valid_out_5(vo[5]),   .valid_out_6(vo[6]),   .valid_out_7(vo[7]),   .valid_out_8(vo[8]),
        .valid_out_9(vo[9]),   .valid_out_10(vo[10]), .valid_out_11(vo[11]), .valid_out_12(vo[12]),
        .valid_out_13(vo[13]), .valid_out_14(vo[14]), .valid_out_15(vo[15]), .valid_out_16(vo[16]),
        .valid_out_17(vo[17]), .valid_out_18(vo[18]), .valid_out_19(vo[19]), .valid_out_20(vo[20]),
        .valid_out_21(vo[21]), .valid_out_22(vo[22]), .valid_out_23(vo[23]), .valid_out_24(vo[24]),
        .valid_out_25(vo[25]), .valid_out_26(vo[26]), .valid_out_27(vo[27]), .valid_out_28(vo[28]),
        .valid_out_29(vo[29]), .valid_out_30(vo[30]), .valid_out_31(vo[31]), .valid_out_32(vo[32])
    );

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Frame content: 0 = all ones, 1 = R ramp of pixel index, 2 = R = -1
    function automatic logic [W-1:0] pix(input int m, input int ch, input int i);
        case (m)
            0:       return 32'd1;
            1:       return (ch == 0) ? W'(i) : 32'd0;
            2:       return (ch == 0) ? 32'hFFFF_FFFF : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    // R + 2G + 3B summed over the 3x3 window ending at pixel i
    function automatic logic [W-1:0] win_sum(input int m, input int i);
        logic [W-1:0] t;
        int r, c, j;
        t = 32'd0;
        r = i / D;
        c = i % D;
        for (int dr = 0; dr < 3; dr++) begin
            for (int dc = 0; dc < 3; dc++) begin
                j = (r - dr) * D + (c - dc);
                t = t + pix(m, 0, j) + 32'd2 * pix(m, 1, j) + 32'd3 * pix(m, 2, j);
            end
        end
        return t;
    endfunction

    task automatic outputs_check(input logic ev, input logic [W-1:0] t);
        check("valid_out", vo, ev ? 32'hFFFF_FFFF : 32'h0000_0000);
        for (int k = 1; k <= 32; k++) begin
            if (ev) last_exp[k] = t * W'(k);
            check($sformatf("pxl_out_%0d", k), po[k], last_exp[k]);
        end
    endtask

    task automatic accept();
        int r, c;
        logic ev;
        r  = idx / D;
        c  = idx % D;
        ev = (r >= 2) && (c >= 2) && (r % 2 == 0) && (c % 2 == 0);
        {v1, v2, v3} = 3'b111;
        p1 = pix(mode, 0, idx);
        p2 = pix(mode, 1, idx);
        p3 = pix(mode, 2, idx);
        @(posedge clk); #1;
        outputs_check(ev, ev ? win_sum(mode, idx) : 32'd0);
        if (ev) pulses++;
        idx = (idx + 1) % (D * D);
    endtask

    task automatic stall(input int n);
        for (int s = 0; s < n; s++) begin
            {v1, v2, v3} = 3'($urandom_range(0, 6));
            p1 = $urandom;
            p2 = $urandom;
            p3 = $urandom;
            @(posedge clk); #1;
            outputs_check(1'b0, 32'd0);
        end
    endtask

    task automatic hold_reset(input int n);
        reset = 1'b0;
        {v1, v2, v3} = 3'b111;
        for (int s = 0; s < n; s++) begin
            p1 = $urandom;
            p2 = $urandom;
            p3 = $urandom;
            @(posedge clk); #1;
            for (int k = 1; k <= 32; k++) last_exp[k] = 32'd0;
            outputs_check(1'b0, 32'd0);
        end
        reset = 1'b1;
        idx   = 0;
    endtask

    task automatic run_frame(input int m);
        mode   = m;
        pulses = 0;
        for (int i = 0; i < D * D; i++) accept();
        check($sformatf("pulses_mode%0d", m), pulses, 32'd16);
    endtask

    initial begin
        reset = 1'b0;
        {v1, v2, v3} = 3'b000;
        p1 = '0; p2 = '0; p3 = '0;
        for (int k = 1; k <= 32; k++) last_exp[k] = 32'd0;
        idx = 0;

        // 1: reset with valid inputs, then one idle cycle after release
        hold_reset(3);
        stall(1);

        // 2: constant frame
        mode = 0; pulses = 0;
        for (int i = 0; i < D * D; i++) begin
            accept();
            if (i == 20) begin
                check("const_first_k1", po[1], 32'd54);
                check("const_first_k32", po[32], 32'd1728);
            end
        end
        check("const_pulses", pulses, 32'd16);

        // 3: ramp on R
        mode = 1; pulses = 0;
        for (int i = 0; i < D * D; i++) begin
            accept();
            if (i == 20) begin
                check("ramp_first_k1", po[1], 32'd90);
                check("ramp_first_k32", po[32], 32'd2880);
            end
            if (i == 22) check("ramp_second_k1", po[1], 32'd108);
        end
        check("ramp_pulses", pulses, 32'd16);

        // 4: ramp with random stalls and partial valids
        mode = 1; pulses = 0;
        for (int i = 0; i < D * D; i++) begin
            if ($urandom_range(0, 4) == 0) stall($urandom_range(1, 3));
            accept();
        end
        check("stall_pulses", pulses, 32'd16);

        // 5: 20 back-to-back constant frames
        begin
            int total;
            total = 0;
            for (int f = 0; f < 20; f++) begin
                run_frame(0);
                total += pulses;
            end
            check("b2b_total_pulses", total, 32'd320);
        end

        // 6: negative wrap, reset at pixel 40, restart
        mode = 2; pulses = 0;
        for (int i = 0; i < 40; i++) accept();
        check("neg_k1", po[1], 32'hFFFF_FFF7);
        check("neg_k32", po[32], 32'hFFFF_FEE0);
        hold_reset(1);
        mode = 2; pulses = 0;
        for (int i = 0; i < D * D; i++) begin
            accept();
            if (i == 20) begin
                check("neg_restart_valid", {31'd0, vo[1]}, 32'd1);
                check("neg_restart_k1", po[1], 32'hFFFF_FFF7);
            end
        end
        check("neg_pulses", pulses, 32'd16);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
